// File: rtl/risc_v_multicycle_controller.sv
`default_nettype none
// ============================================================================
// risc_v_multicycle_controller : RV32I multicycle control FSM (shared ALU,
// unified memory). Rev 1.0
// ============================================================================
module risc_v_multicycle_controller #(
  parameter int unsigned TRAP_ON_ILLEGAL = 1,
  parameter int unsigned STATE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [3:0]         alu_control,
  output logic               instr_retired,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR_ADR = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] S_ILLEGAL_NEXT = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

  logic [3:0] cur_state;
  logic [3:0] next_state;
  logic       legal_op;
  logic       branch_taken;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       retired_raw;

  // Branch funct3 010/011 has no encoding in RV32I, so it counts as illegal.
  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
        legal_op = 1'b1;
      OP_BRANCH: legal_op = (funct3[2:1] != 2'b01);
      default:   legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (cur_state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        if (!legal_op) begin
          next_state = S_ILLEGAL_NEXT;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: next_state = S_MEMADR;
            OP_R:              next_state = S_EXEC_R;
            OP_I:              next_state = S_EXEC_I;
            OP_BRANCH:         next_state = S_BRANCH;
            OP_JAL:            next_state = S_JAL;
            OP_JALR:           next_state = S_JALR_ADR;
            OP_LUI:            next_state = S_LUI;
            OP_AUIPC:          next_state = S_AUIPC;
            default:           next_state = S_ILLEGAL_NEXT;
          endcase
        end
      end
      S_MEMADR:   next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXEC_R:   next_state = S_ALUWB;
      S_EXEC_I:   next_state = S_ALUWB;
      S_LUI:      next_state = S_ALUWB;
      S_AUIPC:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JALR_ADR: next_state = S_JAL;
      S_JAL:      next_state = S_ALUWB;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // bge/bgeu are computed as slt/sltu: "not less than" shows up as zero.
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = ~zero;
      3'b101:  branch_taken = zero;
      3'b110:  branch_taken = ~zero;
      3'b111:  branch_taken = zero;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    retired_raw   = 1'b0;
    illegal_instr = 1'b0;
    imm_src       = IMM_I;

    case (opcode)
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:          imm_src = IMM_I;
    endcase

    case (cur_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_DECODE: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        retired_raw = !legal_op && (TRAP_ON_ILLEGAL == 0);
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retired_raw   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        retired_raw   = 1'b1;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = (cur_state == S_EXEC_I) ? 2'b01 : 2'b00;
        case (funct3)
          3'b000:  alu_control = (funct7b5 && opcode == OP_R && cur_state == S_EXEC_R)
                                 ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retired_raw   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        retired_raw  = 1'b1;
        pc_write_raw = branch_taken;
        case (funct3[2:1])
          2'b00:   alu_control = ALU_SUB;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_ADD;
        endcase
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: ;
    endcase
  end

  // Architectural strobes are gated so nothing is written while reset is held.
  assign pc_write      = pc_write_raw  & ~reset;
  assign mem_write     = mem_write_raw & ~reset;
  assign ir_write      = ir_write_raw  & ~reset;
  assign reg_write     = reg_write_raw & ~reset;
  assign instr_retired = retired_raw   & ~reset;
  assign state         = STATE_W'(cur_state);

endmodule
`default_nettype wire

// File: tb/tb_risc_v_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_risc_v_multicycle_controller : scoreboard bench for both trap settings.
// Rev 1.0
// ============================================================================
module tb_risc_v_multicycle_controller;

  localparam logic [3:0] F  = 4'd0,  D  = 4'd1,  MA = 4'd2,  MR = 4'd3;
  localparam logic [3:0] MW = 4'd4,  MS = 4'd5,  XR = 4'd6,  XI = 4'd7;
  localparam logic [3:0] WB = 4'd8,  BR = 4'd9,  JL = 4'd10, JR = 4'd11;
  localparam logic [3:0] LU = 4'd12, AU = 4'd13, TR = 4'd14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic reset, zero, funct7b5;
  logic [6:0] opcode;
  logic [2:0] funct3;

  // Index 1: TRAP_ON_ILLEGAL=1 instance, index 0: TRAP_ON_ILLEGAL=0 instance.
  logic [1:0]      pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]      instr_retired, illegal_instr;
  logic [1:0][1:0] result_src, alu_src_a, alu_src_b;
  logic [1:0][2:0] imm_src;
  logic [1:0][3:0] alu_control, state;

  always #5 clk = ~clk;

  risc_v_multicycle_controller #(.TRAP_ON_ILLEGAL(1), .STATE_W(4)) dut_trap (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write[1]), .adr_src(adr_src[1]), .mem_write(mem_write[1]),
    .ir_write(ir_write[1]), .reg_write(reg_write[1]), .result_src(result_src[1]),
    .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .imm_src(imm_src[1]),
    .alu_control(alu_control[1]), .instr_retired(instr_retired[1]),
    .illegal_instr(illegal_instr[1]), .state(state[1])
  );

  risc_v_multicycle_controller #(.TRAP_ON_ILLEGAL(0), .STATE_W(4)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write[0]), .adr_src(adr_src[0]), .mem_write(mem_write[0]),
    .ir_write(ir_write[0]), .reg_write(reg_write[0]), .result_src(result_src[0]),
    .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .imm_src(imm_src[0]),
    .alu_control(alu_control[0]), .instr_retired(instr_retired[0]),
    .illegal_instr(illegal_instr[0]), .state(state[0])
  );

  typedef struct packed {
    logic [23:0] e1;
    logic [23:0] e0;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] observed(input int k);
    return {state[k], pc_write[k], adr_src[k], mem_write[k], ir_write[k], reg_write[k],
            result_src[k], alu_src_a[k], alu_src_b[k], imm_src[k], alu_control[k],
            instr_retired[k], illegal_instr[k]};
  endfunction

  function automatic logic [23:0] model(input logic [3:0] st, input bit trap,
                                        input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic z, input bit rst);
    logic pcw, adr, mw, irw, rw, ret, ill;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [3:0] tbl [8];
    bit bad;
    tbl = '{4'b0000, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b1000, 4'b0011, 4'b0010};
    {pcw, adr, mw, irw, rw, ret, ill} = '0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 4'b0000;
    bad = !(op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
          || (op == OP_BR && (f3 == 3'd2 || f3 == 3'd3));
    if (op == OP_STORE) imm = 3'b001;
    else if (op == OP_BR) imm = 3'b010;
    else if (op == OP_JAL) imm = 3'b011;
    else if (op == OP_LUI || op == OP_AUIPC) imm = 3'b100;
    else imm = 3'b000;
    case (st)
      F:  begin irw = 1; sb = 2; rs = 2; pcw = 1; end
      D:  begin sa = 1; sb = 1; ret = !trap && bad; end
      MA: begin sa = 2; sb = 1; end
      MR: adr = 1;
      MW: begin rs = 1; rw = 1; ret = 1; end
      MS: begin adr = 1; mw = 1; ret = 1; end
      XR, XI: begin
        sa = 2;
        sb = (st == XI) ? 2'd1 : 2'd0;
        alu = tbl[f3];
        if (f7 && f3 == 3'd5) alu = 4'b1001;
        if (f7 && f3 == 3'd0 && st == XR) alu = 4'b0001;
      end
      LU: begin sa = 3; sb = 1; end
      AU: begin sa = 1; sb = 1; end
      WB: begin rw = 1; ret = 1; end
      BR: begin
        sa = 2; ret = 1;
        case (f3)
          3'd0: begin alu = 4'b0001; pcw = z;  end
          3'd1: begin alu = 4'b0001; pcw = !z; end
          3'd4: begin alu = 4'b0101; pcw = !z; end
          3'd5: begin alu = 4'b0101; pcw = z;  end
          3'd6: begin alu = 4'b0110; pcw = !z; end
          3'd7: begin alu = 4'b0110; pcw = z;  end
          default: ;
        endcase
      end
      JR: begin sa = 2; sb = 1; end
      JL: begin sa = 1; sb = 2; pcw = 1; end
      TR: ill = 1;
      default: ;
    endcase
    if (rst) {pcw, irw, rw, mw, ret} = '0;
    return {st, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ret, ill};
  endfunction

  // Drives one instruction, queues expected per-cycle outputs, then checks each
  // cycle at the falling edge. Reset is raised from cycle rst_idx onward.
  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input int n,
                     input logic [63:0] s1, input logic [63:0] s0, input int rst_idx);
    exp_t e;
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    for (int i = 0; i < n; i++) begin
      bit r = (rst_idx >= 0) && (i >= rst_idx);
      sb_q.push_back('{model(s1[4*i +: 4], 1'b1, op, f3, f7, z, r),
                       model(s0[4*i +: 4], 1'b0, op, f3, f7, z, r)});
    end
    for (int i = 0; i < n; i++) begin
      if (i == rst_idx) reset = 1'b1;
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s[%0d]: got empty scoreboard expected entry", tag, i);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s[%0d].trap", tag, i), observed(1), e.e1);
        check($sformatf("%s[%0d].nop", tag, i),  observed(0), e.e0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [63:0] t1, t0;
    reset = 1'b1; opcode = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    run("reset", OP_R, 3'd0, 1'b0, 1'b0, 3, 64'({F, F, F}), 64'({F, F, F}), 0);
    reset = 1'b0;

    run("sub",   OP_R,     3'd0, 1'b1, 1'b0, 4, 64'({WB, XR, D, F}), 64'({WB, XR, D, F}), -1);
    run("xor",   OP_R,     3'd4, 1'b0, 1'b0, 4, 64'({WB, XR, D, F}), 64'({WB, XR, D, F}), -1);
    run("addi",  OP_I,     3'd0, 1'b1, 1'b0, 4, 64'({WB, XI, D, F}), 64'({WB, XI, D, F}), -1);
    run("srai",  OP_I,     3'd5, 1'b1, 1'b0, 4, 64'({WB, XI, D, F}), 64'({WB, XI, D, F}), -1);
    run("load",  OP_LOAD,  3'd2, 1'b0, 1'b0, 5, 64'({MW, MR, MA, D, F}), 64'({MW, MR, MA, D, F}), -1);
    run("store", OP_STORE, 3'd2, 1'b0, 1'b0, 4, 64'({MS, MA, D, F}), 64'({MS, MA, D, F}), -1);
    run("bltu",  OP_BR,    3'd6, 1'b0, 1'b0, 3, 64'({BR, D, F}), 64'({BR, D, F}), -1);
    run("bgeu",  OP_BR,    3'd7, 1'b0, 1'b0, 3, 64'({BR, D, F}), 64'({BR, D, F}), -1);
    run("beq",   OP_BR,    3'd0, 1'b0, 1'b1, 3, 64'({BR, D, F}), 64'({BR, D, F}), -1);
    run("bne",   OP_BR,    3'd1, 1'b0, 1'b1, 3, 64'({BR, D, F}), 64'({BR, D, F}), -1);
    run("blt",   OP_BR,    3'd4, 1'b0, 1'b0, 3, 64'({BR, D, F}), 64'({BR, D, F}), -1);
    run("jalr",  OP_JALR,  3'd0, 1'b0, 1'b0, 5, 64'({WB, JL, JR, D, F}), 64'({WB, JL, JR, D, F}), -1);
    run("jal",   OP_JAL,   3'd0, 1'b0, 1'b0, 4, 64'({WB, JL, D, F}), 64'({WB, JL, D, F}), -1);
    run("lui",   OP_LUI,   3'd0, 1'b0, 1'b0, 4, 64'({WB, LU, D, F}), 64'({WB, LU, D, F}), -1);
    run("auipc", OP_AUIPC, 3'd0, 1'b0, 1'b0, 4, 64'({WB, AU, D, F}), 64'({WB, AU, D, F}), -1);

    run("rst_memread", OP_LOAD, 3'd2, 1'b0, 1'b0, 5, 64'({F, MR, MA, D, F}),
        64'({F, MR, MA, D, F}), 3);
    reset = 1'b0;
    run("post_rst", OP_R, 3'd7, 1'b0, 1'b0, 4, 64'({WB, XR, D, F}), 64'({WB, XR, D, F}), -1);

    t1 = '0; t0 = '0;
    for (int i = 0; i < 15; i++) begin
      t1[4*i +: 4] = (i == 0) ? F : (i == 1) ? D : TR;
      t0[4*i +: 4] = (i % 2 == 1) ? D : F;
    end
    run("illegal", 7'b0000000, 3'd0, 1'b0, 1'b0, 15, t1, t0, 14);
    reset = 1'b0;
    run("after_trap", OP_LUI, 3'd0, 1'b0, 1'b0, 4, 64'({WB, LU, D, F}), 64'({WB, LU, D, F}), -1);

    run("br_f3_011", OP_BR, 3'd3, 1'b0, 1'b1, 5, 64'({TR, TR, TR, D, F}),
        64'({F, D, F, D, F}), 4);
    reset = 1'b0;
    run("final", OP_AUIPC, 3'd0, 1'b0, 1'b0, 4, 64'({WB, AU, D, F}), 64'({WB, AU, D, F}), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
